// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath (master) and the hazard scheduler (slave).
// Carries the hazard-detection inputs and the stage enable/flush/status outputs.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             ifid_uses_rt_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic             branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ack_i;
    logic             pc_en_o;
    logic             ifid_en_o;
    logic             ifid_flush_o;
    logic             idex_en_o;
    logic             idex_flush_o;
    logic             exmem_en_o;
    logic             memwb_en_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        input  pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o,
               exmem_en_o, memwb_en_o, err_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        output pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o,
               exmem_en_o, memwb_en_o, err_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, taken-branch flushes,
// data-memory freezes with a watchdog, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int               WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic frozen;
    logic load_use;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;

    always_comb begin
        frozen = ((state_q == ST_RUN) && bus.dmem_req_i && !bus.dmem_ack_i) ||
                 ((state_q == ST_MEM_WAIT) && !bus.dmem_ack_i);
        load_use = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                   ((bus.idex_rt_i == bus.ifid_rs_i) ||
                    (bus.ifid_uses_rt_i && (bus.idex_rt_i == bus.ifid_rt_i)));
    end

    // Reset, HALT and freeze all leave every enable and flush low; load-use outranks branch.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        if (rst_i && (state_q != ST_HALT) && !frozen) begin
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (load_use) begin
                idex_flush = 1'b1;
            end else begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = bus.branch_taken_i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (bus.dmem_req_i && !bus.dmem_ack_i) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_ack_i) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Reset cycles never reach these flops, so they are not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_en_o      = pc_en;
    assign bus.ifid_en_o    = ifid_en;
    assign bus.ifid_flush_o = ifid_flush;
    assign bus.idex_en_o    = idex_en;
    assign bus.idex_flush_o = idex_flush;
    assign bus.exmem_en_o   = exmem_en;
    assign bus.memwb_en_o   = memwb_en;
    assign bus.err_o        = rst_i && (state_q == ST_HALT);
    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.flush_cnt_o  = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with a short watchdog and 4-bit counters.
module tb_pipeline_hazard_ctrl;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    // Packed control view: {pc, ifid_en, ifid_flush, idex_en, idex_flush, exmem, memwb, err}
    localparam logic [7:0] C_OFF    = 8'b0000_0000;
    localparam logic [7:0] C_NORMAL = 8'b1101_0110;
    localparam logic [7:0] C_STALL  = 8'b0001_1110;
    localparam logic [7:0] C_BRANCH = 8'b1111_0110;
    localparam logic [7:0] C_HALT   = 8'b0000_0001;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] idrt;
        logic       branch;
        logic       req;
        logic       ack;
        logic [7:0] exp;
    } stim_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [7:0] exp_q[$];

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [7:0] get_ctrl();
        return {bus.pc_en_o, bus.ifid_en_o, bus.ifid_flush_o, bus.idex_en_o,
                bus.idex_flush_o, bus.exmem_en_o, bus.memwb_en_o, bus.err_o};
    endfunction

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                                 input logic memread, input logic [4:0] idrt, input logic branch,
                                 input logic req, input logic ack, input logic [7:0] exp);
        stim_t s;
        s.rs = rs; s.rt = rt; s.uses_rt = uses_rt; s.memread = memread; s.idrt = idrt;
        s.branch = branch; s.req = req; s.ack = ack; s.exp = exp;
        return s;
    endfunction

    task automatic idle_inputs();
        bus.ifid_rs_i      = 5'd0;
        bus.ifid_rt_i      = 5'd0;
        bus.ifid_uses_rt_i = 1'b0;
        bus.idex_memread_i = 1'b0;
        bus.idex_rt_i      = 5'd0;
        bus.branch_taken_i = 1'b0;
        bus.dmem_req_i     = 1'b0;
        bus.dmem_ack_i     = 1'b0;
    endtask

    task automatic drive(input stim_t s);
        @(negedge clk);
        bus.ifid_rs_i      = s.rs;
        bus.ifid_rt_i      = s.rt;
        bus.ifid_uses_rt_i = s.uses_rt;
        bus.idex_memread_i = s.memread;
        bus.idex_rt_i      = s.idrt;
        bus.branch_taken_i = s.branch;
        bus.dmem_req_i     = s.req;
        bus.dmem_ack_i     = s.ack;
        exp_q.push_back(s.exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (get_ctrl() !== C_OFF || bus.stall_cnt_o !== 4'd0 || bus.flush_cnt_o !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: ctrl=%b stall=%0d flush=%0d, expected ctrl=%b counters 0",
                     get_ctrl(), bus.stall_cnt_o, bus.flush_cnt_o, C_OFF);
        end
        bus.idex_memread_i = 1'b1;
        bus.idex_rt_i      = 5'd8;
        bus.ifid_rs_i      = 5'd8;
        bus.branch_taken_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (get_ctrl() !== C_OFF || bus.stall_cnt_o !== 4'd0 || bus.flush_cnt_o !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_not_counted: ctrl=%b stall=%0d flush=%0d, expected ctrl=%b counters 0",
                     get_ctrl(), bus.stall_cnt_o, bus.flush_cnt_o, C_OFF);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic run_seq(input string name, input stim_t seq[$]);
        logic [7:0] exp;
        foreach (seq[i]) begin
            drive(seq[i]);
            #1;
            exp = exp_q.pop_front();
            vectors++;
            if (get_ctrl() !== exp) begin
                miscompares++;
                $display("FAIL %s[%0d]: ctrl=%b expected %b", name, i, get_ctrl(), exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        stim_t seq[$];
        do_reset();
        seq.push_back(mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_STALL));
        seq.push_back(mk(5'd8, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORMAL));
        run_seq("load_use", seq);
        vectors++;
        if (bus.stall_cnt_o !== 4'd1 || bus.flush_cnt_o !== 4'd0) begin
            miscompares++;
            $display("FAIL load_use_counters: stall=%0d flush=%0d, expected 1 and 0",
                     bus.stall_cnt_o, bus.flush_cnt_o);
        end
    endtask

    task automatic test_no_false_hazard();
        stim_t seq[$];
        do_reset();
        seq.push_back(mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NORMAL));
        seq.push_back(mk(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_NORMAL));
        seq.push_back(mk(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_STALL));
        seq.push_back(mk(5'd3, 5'd9, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, C_NORMAL));
        run_seq("no_false_hazard", seq);
        vectors++;
        if (bus.stall_cnt_o !== 4'd1) begin
            miscompares++;
            $display("FAIL no_false_hazard_stall_cnt: got %0d expected 1", bus.stall_cnt_o);
        end
    endtask

    task automatic test_branch();
        stim_t seq[$];
        do_reset();
        seq.push_back(mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_BRANCH));
        seq.push_back(mk(5'd8, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, C_STALL));
        seq.push_back(mk(5'd8, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_BRANCH));
        run_seq("branch", seq);
        vectors++;
        if (bus.flush_cnt_o !== 4'd2 || bus.stall_cnt_o !== 4'd1) begin
            miscompares++;
            $display("FAIL branch_counters: flush=%0d stall=%0d, expected 2 and 1",
                     bus.flush_cnt_o, bus.stall_cnt_o);
        end
    endtask

    task automatic test_mem_freeze();
        stim_t seq[$];
        do_reset();
        seq.push_back(mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, C_OFF));
        seq.push_back(mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, C_OFF));
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, C_OFF));
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, C_BRANCH));
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_NORMAL));
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORMAL));
        run_seq("mem_freeze", seq);
        vectors++;
        if (bus.stall_cnt_o !== 4'd3 || bus.flush_cnt_o !== 4'd1) begin
            miscompares++;
            $display("FAIL mem_freeze_counters: stall=%0d flush=%0d, expected 3 and 1",
                     bus.stall_cnt_o, bus.flush_cnt_o);
        end
    endtask

    task automatic test_watchdog();
        stim_t seq[$];
        do_reset();
        for (int i = 0; i < MEM_TIMEOUT; i++)
            seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_OFF));
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_HALT));
        seq.push_back(mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, C_HALT));
        run_seq("watchdog", seq);
        vectors++;
        if (bus.stall_cnt_o !== 4'd6 || bus.err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL watchdog_halt: stall=%0d err=%b, expected 6 and 1",
                     bus.stall_cnt_o, bus.err_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.err_o !== 1'b0 || bus.stall_cnt_o !== 4'd0 || get_ctrl() !== C_OFF) begin
            miscompares++;
            $display("FAIL watchdog_async_reset: err=%b stall=%0d ctrl=%b, expected 0 0 %b",
                     bus.err_o, bus.stall_cnt_o, get_ctrl(), C_OFF);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        seq.delete();
        seq.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORMAL));
        run_seq("watchdog_recover", seq);
    endtask

    task automatic test_saturation();
        stim_t seq[$];
        do_reset();
        for (int i = 0; i < 20; i++)
            seq.push_back(mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_STALL));
        run_seq("saturation", seq);
        vectors++;
        if (bus.stall_cnt_o !== 4'd15) begin
            miscompares++;
            $display("FAIL stall_saturation: got %0d expected 15", bus.stall_cnt_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.stall_cnt_o !== 4'd0 || bus.flush_cnt_o !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset_counters: stall=%0d flush=%0d expected 0 and 0",
                     bus.stall_cnt_o, bus.flush_cnt_o);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_branch();
        test_mem_freeze();
        test_watchdog();
        test_saturation();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline. Drives the per-stage register enables: PC, IF/ID, ID/EX (its enable input), EX/MEM and MEM/WB.
- Drives the bubble/flush controls and sequences the following:
  - load-use stalls
  - taken-branch flushes (branch resolved in ID)
  - multi-cycle data-memory freezes with a watchdog
- Keeps saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles without dmem_ack_i before entering HALT (>=2).
- CNT_W, 16, width of performance counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- ifid_rs_i  in  5  rs field of the instruction in IF/ID.
- ifid_rt_i  in  5  rt field of the instruction in IF/ID.
- ifid_uses_rt_i  in  1  IF/ID instruction reads rt as a source.
- idex_memread_i  in  1  instruction in ID/EX is a load.
- idex_rt_i  in  5  destination (rt) of the instruction in ID/EX.
- branch_taken_i  in  1  branch in ID resolved taken this cycle.
- dmem_req_i  in  1  MEM stage issues a data-memory access this cycle.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_en_o  out  1  PC write enable.
- ifid_en_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID clear-to-NOP.
- idex_en_o  out  1  ID/EX load enable.
- idex_flush_o  out  1  ID/EX loads zero control fields (bubble).
- exmem_en_o  out  1  EX/MEM load enable.
- memwb_en_o  out  1  MEM/WB load enable.
- err_o  out  1  watchdog expired; pipeline halted.
- stall_cnt_o  out  CNT_W  cycles with pc_en_o=0, saturating.
- flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1, saturating.

Behaviour:
- Decision logic:
  - FSM states: RUN, MEM_WAIT, HALT.
  - Outputs are combinational from state and current inputs (Mealy); state and counters are registered.
- Reset:
  - While rst_i=0: state=RUN, wait counter=0, err_o=0, both counters=0.
  - All enables are forced 0 and flushes 0 while rst_i=0.
  - Reset mid-MEM_WAIT or in HALT returns to RUN immediately.
- freeze condition:
  - Definition: (RUN and dmem_req_i and !dmem_ack_i) or (MEM_WAIT and !dmem_ack_i).
  - Effect: all five enables 0, both flushes 0.
  - Precedence: highest; load-use and branch are ignored while frozen.
- load_use condition:
  - Definition: idex_memread_i, and idex_rt_i!=0, and (idex_rt_i==ifid_rs_i or (ifid_uses_rt_i and idex_rt_i==ifid_rt_i)).
  - If not frozen: pc_en_o=0, ifid_en_o=0, idex_flush_o=1, idex/exmem/memwb enables 1.
  - Yields exactly one bubble: the load advances, so the condition clears next cycle.
- Branch:
  - If branch_taken_i, not frozen and not load_use: ifid_flush_o=1, all enables 1.
  - load_use beats branch; the branch re-evaluates after the bubble.
- Normal cycle: all enables 1, flushes 0.
- Transitions:
  - RUN->MEM_WAIT when dmem_req_i and !dmem_ack_i; wait counter reset to 1.
  - RUN with dmem_req_i and dmem_ack_i same cycle: zero-wait access, no freeze, stay in RUN.
  - MEM_WAIT->RUN on dmem_ack_i. That cycle is not frozen, so normal load_use/branch rules apply.
  - MEM_WAIT, no ack: wait counter increments. When the counter equals MEM_TIMEOUT-1 and still no ack, go to HALT.
  - HALT: all enables 0, flushes 0, err_o=1. Exit only by reset; dmem_ack_i is ignored.
- Counters:
  - Increment on a clock edge when the condition held in that cycle. Saturate at 2^CNT_W-1, no wrap.
  - HALT cycles count as stalls.
  - Reset cycles are not counted.
- dmem_req_i is not sampled in MEM_WAIT; the MEM stage holds it stable while frozen.

Test Plan:
- Load-use: load $t0 in ID/EX (idex_rt_i=8, idex_memread_i=1), IF/ID add with rs=8 -> that cycle pc_en_o=0, ifid_en_o=0, idex_flush_o=1. Next cycle all enables 1. stall_cnt_o=1.
- No false hazard on $zero or unused rt:
  - idex_rt_i=0 matching rs -> no stall.
  - idex_rt_i=9=ifid_rt_i with ifid_uses_rt_i=0 -> no stall.
- Branch flush and priority:
  - branch_taken_i=1 alone -> ifid_flush_o=1, enables 1, flush_cnt_o=1.
  - Same cycle with load_use -> stall only, ifid_flush_o=0.
- Memory freeze:
  - dmem_req_i=1, ack after 3 cycles -> all enables 0 for exactly 3 cycles (entry cycle + 2 MEM_WAIT), then 1 on the ack cycle; stall_cnt_o=3.
  - Zero-wait ack -> no freeze.
- Watchdog: MEM_TIMEOUT=4, req with no ack -> HALT entered after 4 frozen cycles, err_o=1, enables stay 0 despite a later ack. rst_i low -> err_o=0, state RUN.
- Saturation and async reset:
  - CNT_W=4, force 20 stall cycles -> stall_cnt_o holds 15.
  - Assert rst_i low between clock edges -> counters read 0 immediately.
